// File: rtl/vga_pkg.sv
// Shared display constants, overlay FSM state type and the double-dabble
// nibble-correction helper.
package vga_pkg;

   localparam int H_ACTIVE   = 640;
   localparam int V_ACTIVE   = 480;
   localparam int DIGIT_W    = 16;
   localparam int DIGIT_H    = 16;
   localparam int NUM_DIGITS = 4;
   localparam int BCD_W      = 4 * NUM_DIGITS;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      DONE
   } ovl_state_t;

   // Add 3 to every BCD nibble that is 5 or more, so the following left shift carries correctly.
   function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
      logic [BCD_W-1:0] res;
      res = bcd;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/digit_font_rom.sv
// 8x8 glyphs for the decimal digits; row 0 is the top line and bit 7 the
// leftmost pixel. Codes 10-15 draw nothing.
module digit_font_rom (
   input  logic [3:0] digit,
   input  logic [2:0] glyph_row,
   output logic [7:0] row_bits
);

   logic [63:0] glyph;
   logic [5:0]  base;

   always_comb begin
      glyph = 64'h0;
      case (digit)
         4'd0: glyph = 64'h3C666E7666663C00;
         4'd1: glyph = 64'h1838181818187E00;
         4'd2: glyph = 64'h3C66060C30607E00;
         4'd3: glyph = 64'h3C66061C06663C00;
         4'd4: glyph = 64'h0C1C3C6C7E0C0C00;
         4'd5: glyph = 64'h7E607C0606663C00;
         4'd6: glyph = 64'h3C607C6666663C00;
         4'd7: glyph = 64'h7E060C1830303000;
         4'd8: glyph = 64'h3C66663C66663C00;
         4'd9: glyph = 64'h3C66663E060C3800;
         default: glyph = 64'h0;
      endcase
   end

   // Top glyph row sits in the most significant byte.
   assign base     = {3'd7 - glyph_row, 3'b000};
   assign row_bits = glyph[base +: 8];

endmodule

// File: rtl/score_overlay.sv
// Converts the score to BCD once per frame during vertical blanking and draws
// the four digits as a 2x-scaled box over the incoming pixel stream.
module score_overlay
   import vga_pkg::*;
#(
   parameter int X0       = 8,
   parameter int Y0       = 8,
   parameter int TRIG_ROW = V_ACTIVE
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] score,
   input  logic [9:0] row,
   input  logic [9:0] col,
   input  logic       R_in,
   input  logic       G_in,
   input  logic       B_in,
   output logic       R_out,
   output logic       G_out,
   output logic       B_out,
   output logic       busy
);

   ovl_state_t       state_q, state_d;
   logic             trig_q, trig_d;
   logic [9:0]       bin_q, bin_d;
   logic [BCD_W-1:0] bcd_q, bcd_d;
   logic [3:0]       count_q, count_d;
   logic [3:0]       dig_q [NUM_DIGITS];
   logic [3:0]       dig_d [NUM_DIGITS];

   logic [NUM_DIGITS-1:0] zero_run;
   logic [NUM_DIGITS-1:0] blank;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         trig_q  <= 1'b0;
         bin_q   <= '0;
         bcd_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         trig_q  <= trig_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      count_d = count_q;
      trig_d  = (row == 10'(TRIG_ROW)) && (col == 10'd0);
      case (state_q)
         IDLE: begin
            // Only the rising edge starts a conversion, however long row/col hold.
            if (trig_d && !trig_q) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            bin_d   = score;
            bcd_d   = '0;
            count_d = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            {bcd_d, bin_d} = {dd_adjust(bcd_q), bin_q} << 1;
            count_d        = count_q + 4'd1;
            if (count_q == 4'd9) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy = (state_q != IDLE);

   // Digit 0 is the thousands digit; display registers only move in DONE.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign dig_d[gi] = (state_q == DONE) ? bcd_q[BCD_W-1-4*gi -: 4] : dig_q[gi];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               dig_q[gi] <= 4'd0;
            end else begin
               dig_q[gi] <= dig_d[gi];
            end
         end

         if (gi == 0) begin : g_first
            assign zero_run[gi] = (dig_q[gi] == 4'd0);
         end else begin : g_rest
            assign zero_run[gi] = zero_run[gi-1] && (dig_q[gi] == 4'd0);
         end
      end
   endgenerate

   // The units digit always shows, even when the whole score is zero.
   assign blank = zero_run & {1'b0, {(NUM_DIGITS-1){1'b1}}};

   logic [9:0] rel_x, rel_y;
   logic       in_region;
   logic [1:0] di;
   logic [2:0] glyph_row, glyph_col;
   logic [3:0] cur_dig;
   logic [7:0] glyph_bits;
   logic       pix_on;

   assign rel_x     = col - 10'(X0);
   assign rel_y     = row - 10'(Y0);
   assign in_region = (col >= 10'(X0)) && (row >= 10'(Y0)) &&
                      (rel_x < 10'(DIGIT_W * NUM_DIGITS)) && (rel_y < 10'(DIGIT_H));
   assign di        = rel_x[5:4];
   assign glyph_row = rel_y[3:1];
   assign glyph_col = rel_x[3:1];
   assign cur_dig   = dig_q[di];

   digit_font_rom u_font (
      .digit     (cur_dig),
      .glyph_row (glyph_row),
      .row_bits  (glyph_bits)
   );

   assign pix_on = glyph_bits[3'd7 - glyph_col] && !blank[di];

   always_comb begin
      {R_out, G_out, B_out} = {R_in, G_in, B_in};
      if (in_region) begin
         {R_out, G_out, B_out} = pix_on ? 3'b111 : 3'b000;
      end
   end

endmodule
